ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Shares the single-ported main RAM between the instruction and data cache ports of `CPUS` pipelined cores. The datapath's `dpif.datomic` load-linked/store-conditional pairs are resolved here through per-core link registers. Sits between the per-core cache request buses and the RAM model. Data requests take priority over instruction requests, and cores are served round-robin.

## Interface
Parameters:
- `CPUS`, default 2: number of cores; requesters = 2*CPUS.

Ports:
- `CLK`  in  1  clock. One clock domain only.
- `nRST`  in  1  asynchronous, active-low reset.
- `iREN`  in  [CPUS]  instruction read request.
- `iaddr`  in  [CPUS]x32  instruction word address.
- `iwait`  out  [CPUS]  1 = request not yet complete.
- `iload`  out  [CPUS]x32  instruction read data.
- `dREN`, `dWEN`  in  [CPUS]  data read / write request; never both set.
- `datomic`  in  [CPUS]  with dREN = LL; with dWEN = SC.
- `daddr`, `dstore`  in  [CPUS]x32  data address / write data.
- `dwait`  out  [CPUS]  1 = request not yet complete.
- `dload`  out  [CPUS]x32  read data; for SC, 1 = success, 0 = fail.
- `ramREN`, `ramWEN`  out  1  RAM read / write strobe.
- `ramaddr`, `ramstore`  out  32  RAM address / write data.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  ramstate_t  FREE / BUSY / ACCESS / ERROR.

## Operation
- FSM with 2 states: IDLE and GRANT.
- IDLE:
  - Winner = first active dcache request scanning cores from `rr_ptr` upward (mod CPUS).
  - If there is no dcache request, the first active icache request in the same order.
  - On a winner: latch `gnt_core`, `gnt_is_d`, and the request fields; go to GRANT.
  - No RAM strobes are driven in IDLE.
- GRANT, RAM strobes:
  - Drive `ramREN`/`ramWEN`/`ramaddr`/`ramstore` from the latched request.
  - A failing SC drives no strobes.
- GRANT, completion:
  - Complete when `ramstate==ACCESS`; a failing SC completes immediately.
  - On completion, the granted requester's wait output = 0 for that cycle only, and its load output = `ramload` (SC: 1/0).
  - Then `rr_ptr <= gnt_core+1` (mod CPUS) and return to IDLE.
- GRANT, other RAM states:
  - BUSY/FREE: hold.
  - ERROR: hold and keep re-presenting the request (retry).
- Granted requester drops its request before completion: abort to IDLE with no link update and `rr_ptr` unchanged.
- Every non-granted requester with an active request sees wait = 1. Idle requesters see wait = 0, and their load output = 0.
- Link registers, per core {valid, addr[31:0]}:
  - Completed LL sets `valid`, `addr=daddr`.
  - SC succeeds iff `valid && addr==daddr` for its own core.
  - Every completed write (plain, or successful SC) to address A clears `valid` on every core (including the writer) whose `addr==A`.
  - A failed SC clears its own core's `valid`.
  - LL on core k while core j writes: serialized by the FSM, so no race.
- Reset mid-transaction: FSM to IDLE, strobes dropped, links cleared, `rr_ptr=0`. The requester reissues.

## Timing
- Reset values:
  - State IDLE, `rr_ptr=0`, all links invalid.
  - `ramREN=ramWEN=0`, `ramaddr=ramstore=0`.
  - `iwait`/`dwait` = request inputs, `iload`/`dload` = 0.
- Latency:
  - Request sampled at edge N (IDLE → GRANT).
  - RAM strobes are valid from just after edge N.
  - Earliest completion is in the cycle after edge N, if ramstate=ACCESS then.
  - Minimum 2 cycles from request assertion to wait=0.
  - Failing SC: exactly 2 cycles.
- One dead IDLE cycle between back-to-back transactions.
- Requesters hold address/data stable while wait=1. The arbiter uses its latched copy.
- Outputs `*wait`/`*load` are combinational from state and `ramstate`/`ramload`. RAM strobes are combinational from registered state only.

## Structure
- Shared package `cpu_types_pkg`: `word_t`, `ramstate_t` (existing).
- New package `arbiter_pkg`: `arb_state_t` {IDLE, GRANT}, `link_t` {logic valid; word_t addr}.
- One sub-module: `rr_picker`, a combinational round-robin priority encoder (request vector and pointer in, one-hot grant and valid out), instanced twice (d and i).

## Test plan
- Single icache read, core0, iaddr=0x100, RAM ACCESS after 3 BUSY cycles: ramREN=1, ramaddr=0x100. iwait[0] falls in the ACCESS cycle with iload = ramload. Total 5 cycles.
- Simultaneous dREN[1] and iREN[0], rr_ptr=0: core1 data is served first (ramaddr=daddr[1]). Core0 fetch is granted after one IDLE cycle.
- Both cores issuing dREN continuously, RAM always ACCESS: grants alternate 0,1,0,1; neither waits more than 4 cycles.
- LL core0 @0x200, then SC core0 @0x200 data 0xAB: RAM write 0xAB, dload[0]=1, link0 invalid. A second SC → dload[0]=0, no ramWEN, 2 cycles.
- LL core0 @0x200; plain write core1 @0x200; SC core0 @0x200 → SC fails (dload=0), RAM holds core1's value.
- nRST asserted during GRANT with ramREN=1: strobes are 0 immediately, links are cleared, and the reissued request completes normally.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Types local to the RAM arbiter: FSM state and per-core LL/SC link register.
package arbiter_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                valid;
    cpu_types_pkg::word_t addr;
  } link_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: machine word and RAM handshake state.
package cpu_types_pkg;
  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first active request at or above ptr.
module rr_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);
  int unsigned idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = 32'(ptr) + 32'(i);
      if (idx >= N) idx = idx - N;
      if (!valid && req[PW'(idx)]) begin
        gnt[PW'(idx)] = 1'b1;
        valid         = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-ported RAM between per-core icache/dcache ports and
// resolves LL/SC through per-core link registers.
module ram_arbiter
  import cpu_types_pkg::*;
  import arbiter_pkg::*;
#(
  parameter int unsigned CPUS = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS-1:0][31:0] iaddr,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0][31:0] iload,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS-1:0]      datomic,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS-1:0][31:0] dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  ramstate_t            ramstate
);
  localparam int unsigned PW = (CPUS > 1) ? $clog2(CPUS) : 1;

  arb_state_t      state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gnt_core;
  logic            gnt_is_d;
  word_t           lat_addr;
  word_t           lat_store;
  logic            lat_wen;
  logic            lat_atomic;
  link_t           links [CPUS];

  logic [CPUS-1:0] d_req;
  logic [CPUS-1:0] d_gnt;
  logic [CPUS-1:0] i_gnt;
  logic            d_vld;
  logic            i_vld;
  logic [CPUS-1:0] win_c;
  logic [PW-1:0]   win_idx_c;
  link_t           lk_c;
  logic            is_sc_c;
  logic            sc_fail_c;
  logic            req_held_c;
  logic            done_c;
  logic            abort_c;

  assign d_req = dREN | dWEN;

  rr_picker #(.N(CPUS), .PW(PW)) u_pick_d (
    .req   (d_req),
    .ptr   (rr_ptr),
    .gnt   (d_gnt),
    .valid (d_vld)
  );

  rr_picker #(.N(CPUS), .PW(PW)) u_pick_i (
    .req   (iREN),
    .ptr   (rr_ptr),
    .gnt   (i_gnt),
    .valid (i_vld)
  );

  // Data requests beat instruction requests; reduce one-hot winner to an index.
  always_comb begin
    win_c     = d_vld ? d_gnt : i_gnt;
    win_idx_c = '0;
    for (int k = 0; k < CPUS; k++) begin
      if (win_c[k]) win_idx_c = PW'(k);
    end
  end

  // A failing SC never touches the RAM and completes in its first GRANT cycle.
  always_comb begin
    lk_c       = links[gnt_core];
    is_sc_c    = gnt_is_d && lat_wen && lat_atomic;
    sc_fail_c  = (state == GRANT) && is_sc_c && !(lk_c.valid && (lk_c.addr == lat_addr));
    req_held_c = gnt_is_d ? d_req[gnt_core] : iREN[gnt_core];
    done_c     = (state == GRANT) && req_held_c && (sc_fail_c || (ramstate == ACCESS));
    abort_c    = (state == GRANT) && !req_held_c;
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if ((state == GRANT) && !sc_fail_c) begin
      ramREN   = !gnt_is_d || !lat_wen;
      ramWEN   = gnt_is_d && lat_wen;
      ramaddr  = lat_addr;
      ramstore = gnt_is_d ? lat_store : '0;
    end
  end

  always_comb begin
    iwait = iREN;
    dwait = d_req;
    iload = '0;
    dload = '0;
    if (done_c) begin
      if (gnt_is_d) begin
        dwait[gnt_core] = 1'b0;
        dload[gnt_core] = is_sc_c ? {31'd0, !sc_fail_c} : ramload;
      end else begin
        iwait[gnt_core] = 1'b0;
        iload[gnt_core] = ramload;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gnt_core   <= '0;
      gnt_is_d   <= 1'b0;
      lat_addr   <= '0;
      lat_store  <= '0;
      lat_wen    <= 1'b0;
      lat_atomic <= 1'b0;
      for (int k = 0; k < CPUS; k++) links[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_vld || i_vld) begin
            state      <= GRANT;
            gnt_core   <= win_idx_c;
            gnt_is_d   <= d_vld;
            lat_addr   <= d_vld ? daddr[win_idx_c] : iaddr[win_idx_c];
            lat_store  <= d_vld ? dstore[win_idx_c] : '0;
            lat_wen    <= d_vld && dWEN[win_idx_c];
            lat_atomic <= d_vld && datomic[win_idx_c];
          end
        end
        GRANT: begin
          if (abort_c) begin
            state <= IDLE;
          end else if (done_c) begin
            state  <= IDLE;
            rr_ptr <= (32'(gnt_core) == CPUS - 1) ? '0 : gnt_core + 1'b1;
            // LL arms the link; any completed store kills every link on that address.
            if (gnt_is_d && lat_atomic && !lat_wen) begin
              links[gnt_core] <= '{valid: 1'b1, addr: lat_addr};
            end else if (sc_fail_c) begin
              links[gnt_core].valid <= 1'b0;
            end else if (gnt_is_d && lat_wen) begin
              for (int k = 0; k < CPUS; k++) begin
                if (links[k].addr == lat_addr) links[k].valid <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed transactions push expected
// completions, a negedge monitor pops and compares them.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  logic             CLK;
  logic             nRST;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [1:0][31:0] iload;
  logic [1:0]       dREN;
  logic [1:0]       dWEN;
  logic [1:0]       datomic;
  logic [1:0][31:0] daddr;
  logic [1:0][31:0] dstore;
  logic [1:0]       dwait;
  logic [1:0][31:0] dload;
  logic             ramREN;
  logic             ramWEN;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;
  logic [31:0]      ramload;
  ramstate_t        ramstate;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_d;
    int          core;
    logic [31:0] load;
    bit          chk_load;
  } exp_t;
  exp_t sb[$];

  ram_arbiter #(.CPUS(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM model: ACCESS after `lat` BUSY cycles; unwritten word i reads 0xA0000000|i.
  int unsigned lat = 0;
  int unsigned cnt = 0;
  bit [31:0]   mem [256];
  bit [255:0]  wr_flag;

  always @(posedge CLK) begin
    cnt <= (ramREN || ramWEN) ? cnt + 1 : 0;
    if (ramWEN && ramstate == ACCESS) begin
      mem[ramaddr[9:2]]     <= ramstore;
      wr_flag[ramaddr[9:2]] <= 1'b1;
    end
  end

  always_comb begin
    if (!(ramREN || ramWEN)) ramstate = FREE;
    else if (cnt >= lat)     ramstate = ACCESS;
    else                     ramstate = BUSY;
    ramload = wr_flag[ramaddr[9:2]] ? mem[ramaddr[9:2]] : (32'hA000_0000 | 32'(ramaddr[9:2]));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_txn(input bit is_d, input int core, input logic [31:0] load, input bit chk_load);
    exp_t e;
    e.is_d = is_d; e.core = core; e.load = load; e.chk_load = chk_load;
    sb.push_back(e);
  endtask

  task automatic got(input bit is_d, input int core, input logic [31:0] load);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected actual=%0d:%0d required=none t=%0t", is_d, core, $time);
    end else begin
      e = sb.pop_front();
      chk("sb_src", 32'(is_d) * 16 + 32'(core), 32'(e.is_d) * 16 + 32'(e.core));
      if (e.chk_load) chk("sb_load", load, e.load);
    end
  endtask

  // Completion monitor: an active requester seeing wait=0 has finished.
  always @(negedge CLK) begin
    if (nRST) begin
      for (int k = 0; k < 2; k++) begin
        if (iREN[k] && !iwait[k]) got(1'b0, k, iload[k]);
        if ((dREN[k] || dWEN[k]) && !dwait[k]) got(1'b1, k, dload[k]);
      end
    end
  end

  task automatic i_txn(input int c, input logic [31:0] a, output int cyc);
    iaddr[c] = a;
    iREN[c]  = 1'b1;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (iwait[c] && cyc < 60);
    if (iwait[c]) chk("i_timeout", 32'(iwait[c]), 32'd0);
    @(posedge CLK);
    #1;
    iREN[c] = 1'b0;
  endtask

  task automatic d_txn(input int c, input bit wen, input bit at, input logic [31:0] a,
                       input logic [31:0] s, output int cyc);
    daddr[c]   = a;
    dstore[c]  = s;
    datomic[c] = at;
    if (wen) dWEN[c] = 1'b1;
    else     dREN[c] = 1'b1;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (dwait[c] && cyc < 60);
    if (dwait[c]) chk("d_timeout", 32'(dwait[c]), 32'd0);
    @(posedge CLK);
    #1;
    dREN[c]    = 1'b0;
    dWEN[c]    = 1'b0;
    datomic[c] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=done");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int cyc_b;
    nRST = 1'b0;
    iREN = 2'b01; dREN = 2'b10; dWEN = '0; datomic = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    #2;
    chk("rst_iwait", 32'(iwait), 32'h1);
    chk("rst_dwait", 32'(dwait), 32'h2);
    chk("rst_ramREN", 32'(ramREN), 32'h0);
    chk("rst_ramWEN", 32'(ramWEN), 32'h0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    chk("rst_iload", iload[0], 32'h0);
    chk("rst_dload", dload[1], 32'h0);
    iREN = '0; dREN = '0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    // Single fetch, 3 BUSY then ACCESS
    lat = 3;
    expect_txn(1'b0, 0, 32'hA000_0040, 1'b1);
    fork
      i_txn(0, 32'h100, cyc);
      begin
        @(posedge CLK);
        @(negedge CLK);
        chk("t1_ramREN", 32'(ramREN), 32'h1);
        chk("t1_ramaddr", ramaddr, 32'h100);
      end
    join
    chk("t1_latency", 32'(cyc), 32'd5);

    // Data beats instruction; fetch follows after one IDLE cycle
    do_reset();
    lat = 0;
    expect_txn(1'b1, 1, 32'hA000_00C0, 1'b1);
    expect_txn(1'b0, 0, 32'hA000_0041, 1'b1);
    fork
      d_txn(1, 1'b0, 1'b0, 32'h300, 32'h0, cyc);
      i_txn(0, 32'h104, cyc_b);
      begin
        @(posedge CLK);
        @(negedge CLK);
        chk("t2_ramaddr", ramaddr, 32'h300);
      end
    join
    chk("t2_d_latency", 32'(cyc), 32'd2);
    chk("t2_i_latency", 32'(cyc_b), 32'd4);

    // Round-robin with both cores streaming data reads
    do_reset();
    expect_txn(1'b1, 0, 32'hA000_0004, 1'b1);
    expect_txn(1'b1, 1, 32'hA000_0008, 1'b1);
    expect_txn(1'b1, 0, 32'hA000_0005, 1'b1);
    expect_txn(1'b1, 1, 32'hA000_0009, 1'b1);
    fork
      begin
        int c0;
        for (int n = 0; n < 2; n++) begin
          d_txn(0, 1'b0, 1'b0, 32'h10 + 32'(4 * n), 32'h0, c0);
          chk("t3_lat_core0", 32'(c0 <= 4), 32'd1);
        end
      end
      begin
        int c1;
        for (int n = 0; n < 2; n++) begin
          d_txn(1, 1'b0, 1'b0, 32'h20 + 32'(4 * n), 32'h0, c1);
          chk("t3_lat_core1", 32'(c1 <= 4), 32'd1);
        end
      end
    join

    // LL then successful SC, readback, then failing SC
    expect_txn(1'b1, 0, 32'hA000_0080, 1'b1);
    d_txn(0, 1'b0, 1'b1, 32'h200, 32'h0, cyc);
    expect_txn(1'b1, 0, 32'h1, 1'b1);
    fork
      d_txn(0, 1'b1, 1'b1, 32'h200, 32'hAB, cyc);
      begin
        @(posedge CLK);
        @(negedge CLK);
        chk("t4_sc_ramWEN", 32'(ramWEN), 32'h1);
        chk("t4_sc_ramstore", ramstore, 32'hAB);
      end
    join
    expect_txn(1'b1, 0, 32'hAB, 1'b1);
    d_txn(0, 1'b0, 1'b0, 32'h200, 32'h0, cyc);
    expect_txn(1'b1, 0, 32'h0, 1'b1);
    fork
      d_txn(0, 1'b1, 1'b1, 32'h200, 32'hCD, cyc);
      begin
        @(posedge CLK);
        @(negedge CLK);
        chk("t4_scfail_ramWEN", 32'(ramWEN), 32'h0);
      end
    join
    chk("t4_scfail_latency", 32'(cyc), 32'd2);
    expect_txn(1'b1, 0, 32'hAB, 1'b1);
    d_txn(0, 1'b0, 1'b0, 32'h200, 32'h0, cyc);

    // Another core's store breaks the link
    expect_txn(1'b1, 0, 32'hAB, 1'b1);
    d_txn(0, 1'b0, 1'b1, 32'h200, 32'h0, cyc);
    expect_txn(1'b1, 1, 32'h0, 1'b0);
    d_txn(1, 1'b1, 1'b0, 32'h200, 32'h55, cyc);
    expect_txn(1'b1, 0, 32'h0, 1'b1);
    d_txn(0, 1'b1, 1'b1, 32'h200, 32'h77, cyc);
    expect_txn(1'b1, 1, 32'h55, 1'b1);
    d_txn(1, 1'b0, 1'b0, 32'h200, 32'h0, cyc);

    // Reset mid-GRANT clears strobes and links; held request completes afterwards
    expect_txn(1'b1, 1, 32'hA000_0020, 1'b1);
    d_txn(1, 1'b0, 1'b1, 32'h80, 32'h0, cyc);
    lat = 3;
    expect_txn(1'b0, 0, 32'hA000_0030, 1'b1);
    fork
      i_txn(0, 32'hC0, cyc);
      begin
        @(posedge CLK);
        @(negedge CLK);
        chk("t6_pre_ramREN", 32'(ramREN), 32'h1);
        #2;
        nRST = 1'b0;
        #1;
        chk("t6_rst_ramREN", 32'(ramREN), 32'h0);
        chk("t6_rst_ramaddr", ramaddr, 32'h0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
      end
    join
    lat = 0;
    expect_txn(1'b1, 1, 32'h0, 1'b1);
    d_txn(1, 1'b1, 1'b1, 32'h80, 32'h99, cyc);

    repeat (2) @(posedge CLK);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
